// File: rtl/word_unpacker.sv
// word_unpacker: accepts a packed WIDTH-bit word over a valid/ready handshake
// and replays it as FIELD-bit slices, most-significant slice first, one slice
// per accepted output beat.
//
// Optional build macro: UNPACK_BACK2BACK_EN
//   undefined : one IDLE bubble between words (NF+1 cycles per word)
//   defined   : the next word may load on the last-slice handshake, so that
//               out_valid stays high across words (NF cycles per word)
module word_unpacker #(
   parameter int WIDTH = 8,
   parameter int FIELD = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [FIELD-1:0] out_field,
   output logic             out_last
);

   localparam int NF = WIDTH / FIELD;
   localparam int CW = (NF > 1) ? $clog2(NF) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(NF - 1);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q,   cnt_d;

   logic is_last_s;
   logic accept_s;
   logic out_hs_s;

   // Handshake decode; in_ready/out_valid/out_last come from registered state only.
   always_comb begin
      is_last_s = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
            is_last_s = 1'b0;
         end
         EMIT: begin
            out_valid = 1'b1;
            is_last_s = (cnt_q == LAST_IDX);
`ifdef UNPACK_BACK2BACK_EN
            in_ready  = out_ready & is_last_s;
`else
            in_ready  = 1'b0;
`endif
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            is_last_s = 1'b0;
         end
      endcase
      accept_s  = in_valid & in_ready;
      out_hs_s  = out_valid & out_ready;
      out_last  = is_last_s;
      out_field = shreg_q[WIDTH-1 -: FIELD];
   end

   // Next-state: load on accept, shift on non-final handshake, retire on final.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               shreg_d = in_data;
               cnt_d   = {CW{1'b0}};
               state_d = EMIT;
            end else begin
               state_d = IDLE;
            end
         end
         EMIT: begin
            if (out_hs_s) begin
               if (is_last_s) begin
                  if (accept_s) begin
                     // Only reachable with back-to-back loading enabled.
                     shreg_d = in_data;
                     cnt_d   = {CW{1'b0}};
                     state_d = EMIT;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  shreg_d = {shreg_q[WIDTH-FIELD-1:0], {FIELD{1'b0}}};
                  cnt_d   = cnt_q + CW'(1);
                  state_d = EMIT;
               end
            end else begin
               state_d = EMIT;
            end
         end
         default: begin
            state_d = IDLE;
            shreg_d = {WIDTH{1'b0}};
            cnt_d   = {CW{1'b0}};
         end
      endcase
   end

   // State, shift register and slice counter; asynchronous reset discards any word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= {WIDTH{1'b0}};
         cnt_q   <= {CW{1'b0}};
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_word_unpacker.sv
module tb_word_unpacker;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_field;
   logic       out_last;

   int n_cmp;
   int n_bad;

   // Scoreboard entries: {last, field}
   logic [2:0] exp_q[$];

   word_unpacker #(.WIDTH(8), .FIELD(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_field (out_field),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every output handshake pops one expected slice.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_slice: got field %0d last %0d expected none at %0t",
                     out_field, out_last, $time);
         end else begin
            logic [2:0] e;
            e = exp_q.pop_front();
            if ({out_last, out_field} != e) begin
               n_bad++;
               $display("FAIL slice: got field %0d last %0d expected field %0d last %0d at %0t",
                        out_field, out_last, e[1:0], e[2], $time);
            end
         end
      end
   end

   // Present a word, wait for acceptance (bounded), push its hand-computed slices.
   task automatic send_word(input logic [7:0] w,
                            input logic [1:0] e0, input logic [1:0] e1,
                            input logic [1:0] e2, input logic [1:0] e3,
                            output int waited);
      bit done;
      done   = 1'b0;
      waited = 0;
      in_valid = 1'b1;
      in_data  = w;
      while (!done && waited < 40) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
         waited++;
      end
      #1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got no accept expected accept of %0h", w);
      end else begin
         exp_q.push_back({1'b0, e0});
         exp_q.push_back({1'b0, e1});
         exp_q.push_back({1'b0, e2});
         exp_q.push_back({1'b1, e3});
      end
   endtask

   // Wait (bounded) until every expected slice has been seen and the block is idle.
   task automatic drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || out_valid) && k < 60) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (exp_q.size() != 0 || out_valid) begin
         n_bad++;
         $display("FAIL drain_timeout: got %0d slices pending expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w1;
      int w2;
      n_cmp     = 0;
      n_bad     = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;

      // Reset values
      #12;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_last", int'(out_last), 0);
      check("rst_out_field", int'(out_field), 0);
      @(negedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;

      // Basic word with out_ready high, then one bubble cycle.
      send_word(8'b10_01_11_00, 2'd2, 2'd1, 2'd3, 2'd0, w1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("basic_valid", int'(out_valid), 1);
         check("basic_last", int'(out_last), (i == 3) ? 1 : 0);
      end
      @(negedge clk);
      check("basic_bubble_valid", int'(out_valid), 0);
      check("basic_bubble_ready", int'(in_ready), 1);
      drain();

      // Back-pressure: first slice held for 3 cycles.
      out_ready = 1'b0;
      send_word(8'b10_01_11_00, 2'd2, 2'd1, 2'd3, 2'd0, w1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_valid", int'(out_valid), 1);
         check("bp_field", int'(out_field), 2);
         check("bp_last", int'(out_last), 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain();

      // Busy input: 8'hFF presented during EMIT of 8'h1B.
      send_word(8'h1B, 2'd0, 2'd1, 2'd2, 2'd3, w1);
      @(negedge clk);
      check("busy_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      send_word(8'hFF, 2'd3, 2'd3, 2'd3, 2'd3, w2);
`ifdef UNPACK_BACK2BACK_EN
      check("busy_accept_wait", w2, 3);
`else
      check("busy_accept_wait", w2, 4);
`endif
      drain();

`ifdef UNPACK_BACK2BACK_EN
      // Back-to-back words with no bubble.
      send_word(8'h1B, 2'd0, 2'd1, 2'd2, 2'd3, w1);
      in_valid = 1'b1;
      in_data  = 8'hE4;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("b2b_valid", int'(out_valid), 1);
         check("b2b_last", int'(out_last), (i == 3 || i == 7) ? 1 : 0);
         if (i == 3) begin
            check("b2b_in_ready", int'(in_ready), 1);
            exp_q.push_back({1'b0, 2'd3});
            exp_q.push_back({1'b0, 2'd2});
            exp_q.push_back({1'b0, 2'd1});
            exp_q.push_back({1'b1, 2'd0});
            @(posedge clk);
            #1 in_valid = 1'b0;
         end
      end
      drain();
`endif

      // Asynchronous reset mid-cycle during the third slice of 8'hA5.
      send_word(8'hA5, 2'd2, 2'd2, 2'd1, 2'd1, w1);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_in_ready", int'(in_ready), 1);
      check("arst_out_valid", int'(out_valid), 0);
      check("arst_out_field", int'(out_field), 0);
      check("arst_out_last", int'(out_last), 0);
      exp_q.delete();
      @(negedge clk);
      #1 reset = 1'b0;
      check("post_rst_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
      send_word(8'h0F, 2'd0, 2'd0, 2'd3, 2'd3, w1);
      check("post_rst_accept_wait", w1, 1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/word_unpacker.md
# word_unpacker

Serial field unpacker: accepts a packed WIDTH-bit word over a valid/ready handshake and emits it one FIELD-bit slice per beat, most-significant slice first. It is the receive-side inverse of the bit-concatenation blocks, so that `word_unpacker(concat(a, b, ...))` returns a, b, ... in order. It sits between a word-wide producer and a narrow, back-pressurable consumer.

## Interface
- WIDTH, 8, packed input word width; must be a non-zero multiple of FIELD.
- FIELD, 2, output slice width.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  WIDTH  packed word; sampled only on an accept.
- out_valid  output  1  out_field holds a valid slice.
- out_ready  input  1  consumer takes the slice this cycle.
- out_field  output  FIELD  current slice.
- out_last  output  1  current slice is the final slice of its word.

## Operation
- NF = WIDTH/FIELD slices per word.
- Counter width: clog2(NF), minimum 1 bit.
- State machine IDLE / EMIT.
  - Reset enters IDLE.
- IDLE
  - in_ready = 1 and out_valid = 0.
  - Accept (in_valid & in_ready): load shift register with in_data, clear slice counter, go to EMIT.
- EMIT
  - out_valid = 1; out_field = shreg[WIDTH-1 -: FIELD].
  - out_last = 1 when counter == NF-1.
  - Output handshake (out_valid & out_ready), not last slice: shift register shifts left by FIELD with zero fill; counter increments.
  - Output handshake on last slice: go to IDLE, unless a back-to-back load applies (see Configuration).
  - out_ready low: shreg, counter, out_field and out_last hold. No slice is dropped or duplicated.
- in_valid while not ready: ignored. in_data is don't-care.
- Special case NF = 1: each word is a single beat with out_last = 1.
- Reset mid-word: the partially emitted word is discarded. The first cycle after release is IDLE with in_ready = 1.

## Timing
- Reset values:
  - in_ready = 1.
  - out_valid = 0, out_last = 0, out_field = 0.
  - Shift register = 0, counter = 0.
- Latency:
  - in_data accepted at edge N gives the first slice valid from edge N to edge N+1.
  - in_ready, out_valid and out_last are decoded from registered state only. They have no combinational path from in_valid.
  - in_ready depends combinationally on out_ready only when UNPACK_BACK2BACK_EN is defined.
- Throughput with out_ready held high:
  - Without the macro: NF+1 cycles per word (one IDLE bubble).
  - With the macro: NF cycles per word.
- out_field during IDLE holds the last shifted value. Consumers must qualify it with out_valid.

## Configuration
- UNPACK_BACK2BACK_EN
- Defined:
  - In EMIT, in_ready = out_ready & out_last.
  - A simultaneous last-slice handshake and input accept loads the new word, clears the counter and stays in EMIT.
  - out_valid remains 1 with no bubble.
- Undefined:
  - in_ready = 1 only in IDLE.
  - After the last slice the block always spends one cycle in IDLE.

## Test plan
- Reset asserted asynchronously mid-cycle -> in_ready = 1, out_valid = 0, out_field = 2'b00 immediately, before the next clk edge.
- Defaults, out_ready = 1: accept 8'b10_01_11_00 -> out_field 2'b10, 2'b01, 2'b11, 2'b00 on four consecutive cycles; out_last = 1 only on 2'b00; then out_valid = 0 for one cycle without the macro.
- Back-pressure: same word, out_ready low for 3 cycles after the first slice -> 2'b10 held stable for those cycles; then 2'b01, 2'b11, 2'b00 follow, with no loss or repeat.
- Busy input: in_valid = 1 with 8'hFF while EMIT of 8'h1B is in progress -> 8'h1B emits 0,1,2,3. Without the macro, 8'hFF is accepted only in the following IDLE cycle and emits 3,3,3,3.
- With UNPACK_BACK2BACK_EN: 8'h1B then 8'hE4 presented continuously -> slices 0,1,2,3,3,2,1,0 on eight consecutive cycles, out_valid never drops, out_last on the 4th and 8th.
- Reset pulse after the second slice of 8'hA5 -> out_valid = 0 at once. The next word 8'h0F emits 0,0,3,3 from its first slice.
